// File: rtl/fetch_unit.sv
// Instruction-fetch front end feeding the IF/ID register.
// Issues sequential PC requests to a variable-latency instruction memory,
// buffers returned words with their PCs in a DEPTH-entry queue, and
// presents one instruction per cycle to decode. Handles decode stalls,
// branch redirects (queue flush and dropping of stale responses) and the
// halt opcode 7'h7F.
//
// Handshakes: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both high; the address is held stable while valid is
// high and not accepted, except when a redirect retargets fetch. Responses
// have no ready: every imem_resp_valid cycle carries one word, in request
// order. Decode pops the head on a rising edge where id_valid and id_ready
// are both high.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic        halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

  // Architectural state
  logic [63:0]   fetch_pc, resp_pc;
  logic [63:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic          halt_seen;
  logic          halted_q;

  // Next-state values
  logic [63:0]   fetch_pc_n, resp_pc_n;
  logic [AW-1:0] head_n, tail_n;
  logic [CW-1:0] count_n, out_n, drop_n;
  logic          halt_n;

  // Per-cycle events
  logic [CW+1:0] budget_used;
  logic          req_fire;
  logic          resp_fire;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic          halt_hit;

  // Request gating: queue slots, in-flight requests and pending drops share one budget
  always_comb begin
    budget_used    = {2'b00, count} + {2'b00, outstanding} + {2'b00, drop_cnt};
    imem_req_valid = !rst && !redirect_valid && !halt_seen && (budget_used < DEPTH_W);
    imem_req_addr  = fetch_pc;
  end

  // Decode-side view of the queue head; blanked when empty or in reset
  always_comb begin
    id_valid = !rst && (count != '0);
    id_instr = id_valid ? instr_mem[head] : 32'd0;
    id_pc    = id_valid ? pc_mem[head]    : 64'd0;
    halted   = halted_q && !rst;
  end

  // Classify this cycle's handshakes; a response with nothing expected is ignored
  always_comb begin
    req_fire  = imem_req_valid && imem_req_ready;
    resp_fire = imem_resp_valid && ((outstanding != '0) || (drop_cnt != '0));
    resp_drop = resp_fire && (drop_cnt != '0);
    push      = resp_fire && (drop_cnt == '0);
    pop       = id_valid && id_ready;
    halt_hit  = push && (imem_resp_data[6:0] == 7'h7F);
  end

  // Next-state: redirect flushes everything, otherwise normal fetch/queue bookkeeping
  always_comb begin
    fetch_pc_n = fetch_pc;
    resp_pc_n  = resp_pc;
    head_n     = head;
    tail_n     = tail;
    count_n    = count;
    out_n      = outstanding;
    drop_n     = drop_cnt;
    halt_n     = halt_seen;
    if (redirect_valid) begin
      fetch_pc_n = redirect_pc;
      resp_pc_n  = redirect_pc;
      head_n     = '0;
      tail_n     = '0;
      count_n    = '0;
      halt_n     = 1'b0;
      // Everything still in flight becomes stale; this cycle's response is one of them.
      drop_n     = drop_cnt + outstanding - (resp_fire ? ONE : '0);
      out_n      = '0;
    end else begin
      if (req_fire) fetch_pc_n = fetch_pc + 64'd4;
      if (push) begin
        resp_pc_n = resp_pc + 64'd4;
        tail_n    = tail + AW'(1);
      end
      if (pop) head_n = head + AW'(1);
      count_n = count + (push ? ONE : '0) - (pop ? ONE : '0);
      out_n   = outstanding + (req_fire ? ONE : '0) - (push ? ONE : '0);
      if (resp_drop) drop_n = drop_cnt - ONE;
      if (halt_hit) begin
        // Requests issued past the halt are never delivered.
        halt_n = 1'b1;
        drop_n = drop_n + out_n;
        out_n  = '0;
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      halt_seen   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      fetch_pc    <= fetch_pc_n;
      resp_pc     <= resp_pc_n;
      head        <= head_n;
      tail        <= tail_n;
      count       <= count_n;
      outstanding <= out_n;
      drop_cnt    <= drop_n;
      halt_seen   <= halt_n;
      halted_q    <= halt_seen && (count == '0) && (outstanding == '0) && (drop_cnt == '0);
    end
  end

  // Queue storage write; contents need no reset since count guards them
  always_ff @(posedge clk) begin
    if (push && !redirect_valid && !rst) begin
      pc_mem[tail]    <= resp_pc;
      instr_mem[tail] <= imem_resp_data;
    end
  end

endmodule
